// File: rtl/dual_rail_pkg.sv
// Shared dual-rail symbol encoding and decoder state type.
// Used by both the bit encoder and the word decoder so the two sides cannot drift.
package dual_rail_pkg;

  // Symbols are written as {x1, x0}.
  localparam logic [1:0] SYM_ZERO    = 2'b01;
  localparam logic [1:0] SYM_ONE     = 2'b10;
  localparam logic [1:0] SYM_SPACER  = 2'b00;
  localparam logic [1:0] SYM_ILLEGAL = 2'b11;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/dual_rail_sym_decode.sv
// Combinational classifier for one sampled dual-rail symbol.
// All outputs are forced low when the strobe is low.
module dual_rail_sym_decode
  import dual_rail_pkg::*;
(
  input  logic e_i,
  input  logic x1_i,
  input  logic x0_i,
  output logic is_data,
  output logic data_bit,
  output logic is_illegal
);

  logic [1:0] sym;

  assign sym        = {x1_i, x0_i};
  assign is_data    = e_i && ((sym == SYM_ZERO) || (sym == SYM_ONE));
  assign data_bit   = e_i && (sym == SYM_ONE);
  assign is_illegal = e_i && (sym == SYM_ILLEGAL);

endmodule

// File: rtl/dual_rail_word_decoder.sv
// Dual-rail receiver: decodes sampled symbols to bits and assembles LSB-first words
// presented on a valid/ready handshake, flagging illegal codes and dropped symbols.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   COLLECT | gathering bits into the shift register, no word presented
//   HOLD    | complete word on word_o with valid_o high, awaiting ready_i
module dual_rail_word_decoder #(
  parameter  int WORD_W = 5,
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              e_i,
  input  logic              x0_i,
  input  logic              x1_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              bit_o,
  output logic              bit_valid_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic [CNT_W-1:0]  cnt_o
);

  import dual_rail_pkg::*;

  logic              is_data;
  logic              data_bit;
  logic              is_illegal;
  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_ins;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_bit;

  dual_rail_sym_decode u_sym_decode (
    .e_i        (e_i),
    .x1_i       (x1_i),
    .x0_i       (x0_i),
    .is_data    (is_data),
    .data_bit   (data_bit),
    .is_illegal (is_illegal)
  );

  // Shift register with the incoming bit dropped into the slot selected by cnt.
  always_comb begin
    shift_ins = shift_q;
    for (int i = 0; i < WORD_W; i++) begin
      if (cnt_q == CNT_W'(i)) shift_ins[i] = data_bit;
    end
  end

  assign last_bit = (cnt_q == CNT_W'(WORD_W - 1));
  assign cnt_o    = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      shift_q     <= '0;
      cnt_q       <= '0;
      word_o      <= '0;
      valid_o     <= 1'b0;
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
      err_o       <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      bit_valid_o <= is_data;
      err_o       <= is_illegal;
      if (is_data) bit_o <= data_bit;

      case (state_q)
        COLLECT: begin
          if (is_illegal) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end else if (is_data) begin
            if (last_bit) begin
              word_o  <= shift_ins;
              valid_o <= 1'b1;
              shift_q <= '0;
              cnt_q   <= '0;
              state_q <= HOLD;
            end else begin
              shift_q <= shift_ins;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state_q <= COLLECT;
          end
          // cnt is always 0 here, so an accepted-cycle symbol lands in bit 0.
          if (is_illegal) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end else if (is_data) begin
            if (ready_i) begin
              shift_q <= shift_ins;
              cnt_q   <= cnt_q + 1'b1;
            end else begin
              ovf_o <= 1'b1;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_rail_word_decoder.sv
// Directed bench for dual_rail_word_decoder: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every accepted word.
module tb_dual_rail_word_decoder;

  localparam int WORD_W = 5;
  localparam int CNT_W  = $clog2(WORD_W + 1);

  logic              clk;
  logic              rst_n;
  logic              e_i;
  logic              x0_i;
  logic              x1_i;
  logic [WORD_W-1:0] word_o;
  logic              valid_o;
  logic              ready_i;
  logic              bit_o;
  logic              bit_valid_o;
  logic              err_o;
  logic              ovf_o;
  logic [CNT_W-1:0]  cnt_o;

  int checks   = 0;
  int failures = 0;
  logic [WORD_W-1:0] exp_q[$];

  dual_rail_word_decoder #(.WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .e_i         (e_i),
    .x0_i        (x0_i),
    .x1_i        (x1_i),
    .word_o      (word_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .err_o       (err_o),
    .ovf_o       (ovf_o),
    .cnt_o       (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply one symbol for one cycle; returns 1 time unit after the sampling edge.
  task automatic step(input logic e, input logic [1:0] sym);
    e_i = e;
    {x1_i, x0_i} = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word"}, 32'(word_o), 32'h0);
    chk({tag, "_valid"}, 32'(valid_o), 32'h0);
    chk({tag, "_bit"}, 32'(bit_o), 32'h0);
    chk({tag, "_bit_valid"}, 32'(bit_valid_o), 32'h0);
    chk({tag, "_err"}, 32'(err_o), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf_o), 32'h0);
    chk({tag, "_cnt"}, 32'(cnt_o), 32'h0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard monitor: a word is consumed when valid && ready at the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_word actual=%0h required=none", word_o);
      end else begin
        logic [WORD_W-1:0] w;
        w = exp_q.pop_front();
        if (word_o !== w) begin
          failures++;
          $display("FAIL sb_word actual=%0h required=%0h", word_o, w);
        end
      end
    end
  end

  localparam logic [1:0] S0 = 2'b01;
  localparam logic [1:0] S1 = 2'b10;
  localparam logic [1:0] SP = 2'b00;
  localparam logic [1:0] IL = 2'b11;

  initial begin
    logic [1:0] t1_syms [5];
    logic [31:0] t1_cnt  [5];
    logic [31:0] t1_bit  [5];
    logic [1:0] t5_syms [10];
    logic [31:0] t5_val [10];

    t1_syms = '{S0, S1, S1, S0, S1};
    t1_cnt  = '{1, 2, 3, 4, 0};
    t1_bit  = '{0, 1, 1, 0, 1};
    t5_syms = '{S1, S1, S1, S1, S1, S1, S0, S0, S0, S0};
    t5_val  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    rst_n = 1'b0; e_i = 1'b0; x0_i = 1'b0; x1_i = 1'b0; ready_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_all_zero("reset");

    // Basic word 10110 with ready held high.
    ready_i = 1'b1;
    exp_q.push_back(5'b10110);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, t1_syms[i]);
      chk("t1_cnt", 32'(cnt_o), t1_cnt[i]);
      chk("t1_bit", 32'(bit_o), t1_bit[i]);
      chk("t1_bit_valid", 32'(bit_valid_o), 32'h1);
    end
    chk("t1_valid", 32'(valid_o), 32'h1);
    chk("t1_word", 32'(word_o), 32'h16);
    idle();
    chk("t1_valid_drop", 32'(valid_o), 32'h0);

    // Same word with spacers and strobed-off garbage interleaved.
    exp_q.push_back(5'b10110);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, t1_syms[i]);
      chk("t2_err_data", 32'(err_o), 32'h0);
      step(1'b1, SP);
      chk("t2_err_spacer", 32'(err_o), 32'h0);
      chk("t2_spacer_bv", 32'(bit_valid_o), 32'h0);
      step(1'b0, IL);
      chk("t2_err_gated", 32'(err_o), 32'h0);
    end
    idle();

    // Illegal code discards a partial word.
    exp_q.push_back(5'b00000);
    step(1'b1, S0); step(1'b1, S1); step(1'b1, S1);
    chk("t3_cnt_pre", 32'(cnt_o), 32'h3);
    step(1'b1, IL);
    chk("t3_err", 32'(err_o), 32'h1);
    chk("t3_cnt_clr", 32'(cnt_o), 32'h0);
    idle();
    chk("t3_err_pulse", 32'(err_o), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, S0);
    chk("t3_valid", 32'(valid_o), 32'h1);
    chk("t3_word", 32'(word_o), 32'h0);
    idle();

    // Held word with ready low, overflow, then accept with a same-cycle symbol.
    ready_i = 1'b0;
    exp_q.push_back(5'b00111);
    step(1'b1, S1); step(1'b1, S1); step(1'b1, S1); step(1'b1, S0); step(1'b1, S0);
    chk("t4_valid", 32'(valid_o), 32'h1);
    chk("t4_ovf_pre", 32'(ovf_o), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, S1);
      chk("t4_word_frozen", 32'(word_o), 32'h07);
      chk("t4_ovf", 32'(ovf_o), 32'h1);
      chk("t4_cnt_hold", 32'(cnt_o), 32'h0);
      chk("t4_bit_valid", 32'(bit_valid_o), 32'h1);
      chk("t4_valid_held", 32'(valid_o), 32'h1);
    end
    idle();
    chk("t4_ovf_sticky", 32'(ovf_o), 32'h1);
    chk("t4_valid_idle", 32'(valid_o), 32'h1);
    exp_q.push_back(5'b00011);
    ready_i = 1'b1;
    step(1'b1, S1);
    chk("t4_accept_valid", 32'(valid_o), 32'h0);
    chk("t4_accept_cnt", 32'(cnt_o), 32'h1);
    step(1'b1, S1); step(1'b1, S0); step(1'b1, S0); step(1'b1, S0);
    chk("t4_next_valid", 32'(valid_o), 32'h1);
    chk("t4_next_word", 32'(word_o), 32'h03);
    idle();
    chk("t4_ovf_keep", 32'(ovf_o), 32'h1);

    // Back-to-back words after a reset clears the overflow flag.
    do_reset();
    chk("t5_ovf_reset", 32'(ovf_o), 32'h0);
    ready_i = 1'b1;
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b00001);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, t5_syms[i]);
      chk("t5_valid_seq", 32'(valid_o), t5_val[i]);
    end
    chk("t5_word2", 32'(word_o), 32'h01);
    chk("t5_ovf", 32'(ovf_o), 32'h0);
    idle();

    // Asynchronous reset mid-word and with a word held.
    step(1'b1, S1); step(1'b1, S0); step(1'b1, S1);
    chk("t6_cnt_pre", 32'(cnt_o), 32'h3);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_rst_partial");
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, S1);
    chk("t6_valid_pre", 32'(valid_o), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_rst_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_i = 1'b1;
    exp_q.push_back(5'b01101);
    step(1'b1, S1); step(1'b1, S0); step(1'b1, S1); step(1'b1, S1); step(1'b1, S0);
    chk("t6_word", 32'(word_o), 32'h0D);
    idle();
    idle();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
